// File: rtl/cluster_event_rx.sv
// Cluster-side receiver of the SoC-to-cluster event ring.
// Brings the asynchronous write tokens into the cluster clock domain and
// consumes ring slots strictly in order. Each consumed slot is returned to the
// SoC side as a toggled read token. Events are presented downstream as a
// registered valid/ready stream.
module cluster_event_rx #(
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [BUFFER_WIDTH-1:0]                events_wt_i,
  input  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0]     events_da_i,
  output logic [BUFFER_WIDTH-1:0]                events_rp_o,
  output logic                                   evt_valid_o,
  output logic [EVNT_WIDTH-1:0]                  evt_data_o,
  input  logic                                   evt_ready_i,
  output logic [$clog2(BUFFER_WIDTH+1)-1:0]      evt_pending_o
);

  localparam int unsigned PTR_W  = $clog2(BUFFER_WIDTH);
  localparam int unsigned PEND_W = $clog2(BUFFER_WIDTH + 1);

  logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] wt_s;
  logic [BUFFER_WIDTH-1:0] rp_q;
  logic [PTR_W-1:0]        ptr_q;
  logic                    valid_q;
  logic [EVNT_WIDTH-1:0]   data_q;
  logic [EVNT_WIDTH-1:0]   slot_data;
  logic [PEND_W-1:0]       pending;
  logic                    avail;
  logic                    cap;

  // Token synchroniser; nothing else looks at the raw write tokens.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= events_wt_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign wt_s = sync_q[SYNC_STAGES-1];

  // Slot ptr is available once its synchronised token differs from our read token.
  assign avail = (wt_s[ptr_q] != rp_q[ptr_q]);
  assign cap   = avail && (!valid_q || evt_ready_i);

  // Select the current slot's data word; only sampled once its token is visible.
  always_comb begin
    slot_data = '0;
    for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
      if (ptr_q == PTR_W'(i)) begin
        slot_data = events_da_i[i*EVNT_WIDTH +: EVNT_WIDTH];
      end
    end
  end

  // Output register, read tokens and ring index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp_q    <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (cap) begin
      data_q        <= slot_data;
      valid_q       <= 1'b1;
      rp_q[ptr_q]   <= ~rp_q[ptr_q];
      ptr_q         <= (ptr_q == PTR_W'(BUFFER_WIDTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end else if (valid_q && evt_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Pending count: slots whose token is visible but not yet consumed.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < BUFFER_WIDTH; i++) begin
      pending = pending + PEND_W'(wt_s[i] ^ rp_q[i]);
    end
  end

  assign events_rp_o   = rp_q;
  assign evt_valid_o   = valid_q;
  assign evt_data_o    = data_q;
  assign evt_pending_o = pending;

`ifndef SYNTHESIS
  logic [BUFFER_WIDTH-1:0] consume_mask;
  logic [BUFFER_WIDTH-1:0] double_tog;

  // Slot being consumed at this edge may legitimately see its token move on.
  always_comb begin
    consume_mask = '0;
    if (cap) begin
      consume_mask[ptr_q] = 1'b1;
    end
  end

  // A pending, unconsumed token must not toggle again (writer protocol error).
  assign double_tog = (sync_q[SYNC_STAGES-2] ^ wt_s) & (wt_s ^ rp_q) & ~consume_mask;

  a_no_double_toggle: assert property (@(posedge clk_i) disable iff (rst_i) double_tog == '0);
`endif

endmodule
